// File: rtl/uplink_axil_regs.sv
// uplink_axil_regs: AXI4-Lite slave exposing four 32-bit RW registers
// (word indices 0-3) plus four unmapped words (indices 4-7).
// Optional macro UPLINK_AXIL_SLVERR_EN: unmapped accesses answer SLVERR
// instead of OKAY. Reads of unmapped words return zero and writes to them
// are discarded in either build.
module uplink_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0]   regs_o,
  output logic [3:0]                        wr_pulse_o
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef UPLINK_AXIL_SLVERR_EN
  localparam logic [1:0] RESP_UNMAPPED = 2'b10;
`else
  localparam logic [1:0] RESP_UNMAPPED = 2'b00;
`endif

  // Register file and write-side state
  logic [DW-1:0]     regs_q [4];
  logic              aw_held_q;
  logic [2:0]        aw_idx_q;
  logic              w_held_q;
  logic [DW-1:0]     w_data_q;
  logic [STRB_W-1:0] w_strb_q;
  logic              bvalid_q;
  logic [1:0]        bresp_q;
  logic [3:0]        wr_pulse_q;

  // Read-side state
  logic              rvalid_q;
  logic [1:0]        rresp_q;
  logic [DW-1:0]     rdata_q;

  // Write-side combinational view
  logic              aw_fire;
  logic              w_fire;
  logic              commit;
  logic [2:0]        cmt_idx;
  logic [DW-1:0]     cmt_data;
  logic [STRB_W-1:0] cmt_strb;
  logic              ar_fire;
  logic [2:0]        ar_idx;

  // Protection bits and byte-offset address bits carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Merge new data into the old word on the byte lanes whose strobe is set.
  function automatic logic [DW-1:0] merge_strb(input logic [DW-1:0]     old_w,
                                               input logic [DW-1:0]     new_w,
                                               input logic [STRB_W-1:0] strb);
    logic [DW-1:0] res;
    res = old_w;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  // Readiness is forced low while reset is asserted so nothing is accepted.
  assign S_AXI_AWREADY = !ARESET && !aw_held_q && !bvalid_q;
  assign S_AXI_WREADY  = !ARESET && !w_held_q  && !bvalid_q;
  assign S_AXI_ARREADY = !ARESET && !rvalid_q;

  assign aw_fire  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_fire   = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_fire  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign ar_idx   = S_AXI_ARADDR[4:2];

  // A held beat pairs with a fresh handshake of its partner, or both arrive together.
  assign commit   = (aw_held_q || aw_fire) && (w_held_q || w_fire);
  assign cmt_idx  = aw_held_q ? aw_idx_q : S_AXI_AWADDR[4:2];
  assign cmt_data = w_held_q  ? w_data_q : S_AXI_WDATA;
  assign cmt_strb = w_held_q  ? w_strb_q : S_AXI_WSTRB;

  // Write path: capture AW/W independently, commit when both present, then respond on B.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_held_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_held_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      wr_pulse_q <= '0;
      if (bvalid_q && S_AXI_BREADY) bvalid_q <= 1'b0;
      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        if (!cmt_idx[2]) begin
          regs_q[cmt_idx[1:0]] <= merge_strb(regs_q[cmt_idx[1:0]], cmt_data, cmt_strb);
          wr_pulse_q           <= 4'b0001 << cmt_idx[1:0];
          bresp_q              <= RESP_OKAY;
        end else begin
          bresp_q              <= RESP_UNMAPPED;
        end
      end else begin
        if (aw_fire) begin
          aw_held_q <= 1'b1;
          aw_idx_q  <= S_AXI_AWADDR[4:2];
        end
        if (w_fire) begin
          w_held_q  <= 1'b1;
          w_data_q  <= S_AXI_WDATA;
          w_strb_q  <= S_AXI_WSTRB;
        end
      end
    end
  end

  // Read path: register data/response on AR handshake; regs_q is sampled
  // before any same-edge commit lands, so a colliding read sees the old value.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      if (rvalid_q && S_AXI_RREADY) rvalid_q <= 1'b0;
      if (ar_fire) begin
        rvalid_q <= 1'b1;
        if (!ar_idx[2]) begin
          rdata_q <= regs_q[ar_idx[1:0]];
          rresp_q <= RESP_OKAY;
        end else begin
          rdata_q <= '0;
          rresp_q <= RESP_UNMAPPED;
        end
      end
    end
  end

  // Flatten the register file, reg0 in the least-significant word.
  always_comb begin
    regs_o = '0;
    for (int i = 0; i < 4; i++) regs_o[DW*i +: DW] = regs_q[i];
  end

  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RRESP  = rresp_q;
  assign S_AXI_RDATA  = rdata_q;
  assign wr_pulse_o   = wr_pulse_q;

endmodule

// File: tb/tb_uplink_axil_regs.sv
// Bench for uplink_axil_regs: directed scenarios plus randomized writes and
// reads checked against an array-based model of the register file.
// Honors UPLINK_AXIL_SLVERR_EN for the expected unmapped response code.
module tb_uplink_axil_regs;

  logic         clk = 1'b0;
  logic         ARESET = 1'b1;
  logic [4:0]   AWADDR = '0;
  logic [2:0]   AWPROT = '0;
  logic         AWVALID = 1'b0;
  logic         AWREADY;
  logic [31:0]  WDATA = '0;
  logic [3:0]   WSTRB = '0;
  logic         WVALID = 1'b0;
  logic         WREADY;
  logic [1:0]   BRESP;
  logic         BVALID;
  logic         BREADY = 1'b0;
  logic [4:0]   ARADDR = '0;
  logic [2:0]   ARPROT = '0;
  logic         ARVALID = 1'b0;
  logic         ARREADY;
  logic [31:0]  RDATA;
  logic [1:0]   RRESP;
  logic         RVALID;
  logic         RREADY = 1'b0;
  logic [127:0] regs_o;
  logic [3:0]   wr_pulse_o;

`ifdef UPLINK_AXIL_SLVERR_EN
  localparam logic [1:0] EXP_UNMAPPED = 2'b10;
`else
  localparam logic [1:0] EXP_UNMAPPED = 2'b00;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] mdl [4];

  uplink_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) dut (
    .ACLK(clk), .ARESET(ARESET),
    .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
    .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
    .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
    .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
    .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mdl_flat();
    return {mdl[3], mdl[2], mdl[1], mdl[0]};
  endfunction

  // Model: a write lands only on mapped words, only on strobed bytes.
  task automatic mdl_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int idx;
    idx = int'(addr) / 4;
    if (idx < 4) begin
      for (int b = 0; b < 4; b++) if (strb[b]) mdl[idx][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  // All tasks start and finish just after a falling edge.
  task automatic do_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done, w_done, aw_hs, w_hs;
    int cyc, idx;
    logic [3:0] exp_pulse;
    aw_done = 0; w_done = 0; cyc = 0;
    BREADY = 1'b0;
    idx = int'(addr) / 4;
    while (!(aw_done && w_done) && cyc < 40) begin
      AWVALID = !aw_done && (cyc >= aw_dly);
      AWADDR  = addr;
      WVALID  = !w_done && (cyc >= w_dly);
      WDATA   = data;
      WSTRB   = strb;
      #1;
      if (w_done && !aw_done) check("wready_low_while_w_held", WREADY, 1'b0);
      if (aw_done && !w_done) check("awready_low_while_aw_held", AWREADY, 1'b0);
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      @(negedge clk);
      aw_done |= aw_hs;
      w_done  |= w_hs;
      cyc++;
    end
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    check("write_accepted", {aw_done, w_done}, 2'b11);
    mdl_write(addr, data, strb);
    exp_pulse = (idx < 4) ? 4'(1 << idx) : 4'b0000;
    check("bvalid_after_commit", BVALID, 1'b1);
    check("bresp", BRESP, (idx < 4) ? 2'b00 : EXP_UNMAPPED);
    check("wr_pulse", wr_pulse_o, exp_pulse);
    for (int i = 0; i < b_dly; i++) begin
      @(negedge clk);
      check("bvalid_held", BVALID, 1'b1);
      check("awready_blocked", AWREADY, 1'b0);
      check("wready_blocked", WREADY, 1'b0);
      check("wr_pulse_one_cycle", wr_pulse_o, 4'b0000);
    end
    BREADY = 1'b1;
    @(negedge clk);
    BREADY = 1'b0;
    check("bvalid_cleared", BVALID, 1'b0);
    check("awready_rearmed", AWREADY, 1'b1);
    check("wr_pulse_idle", wr_pulse_o, 4'b0000);
    check("regs_o_after_write", regs_o, mdl_flat());
  endtask

  task automatic do_read(input logic [4:0] addr);
    int cyc, idx;
    idx = int'(addr) / 4;
    cyc = 0;
    ARVALID = 1'b1;
    ARADDR  = addr;
    RREADY  = 1'b0;
    #1;
    while (!ARREADY && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("arready_seen", ARREADY, 1'b1);
    @(negedge clk);
    ARVALID = 1'b0;
    check("rvalid", RVALID, 1'b1);
    check("rdata", RDATA, (idx < 4) ? mdl[idx] : 32'h0);
    check("rresp", RRESP, (idx < 4) ? 2'b00 : EXP_UNMAPPED);
    RREADY = 1'b1;
    @(negedge clk);
    RREADY = 1'b0;
    check("rvalid_cleared", RVALID, 1'b0);
    check("arready_rearmed", ARREADY, 1'b1);
  endtask

  initial begin
    logic [31:0] old_val;
    logic [4:0]  ra;
    for (int i = 0; i < 4; i++) mdl[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_awready", AWREADY, 1'b0);
    check("rst_wready", WREADY, 1'b0);
    check("rst_arready", ARREADY, 1'b0);
    check("rst_bvalid", BVALID, 1'b0);
    check("rst_rvalid", RVALID, 1'b0);
    check("rst_wr_pulse", wr_pulse_o, 4'b0000);
    check("rst_resp", {BRESP, RRESP}, 4'b0000);
    check("rst_rdata", RDATA, 32'h0);
    check("rst_regs", regs_o, 128'h0);
    ARESET = 1'b0;
    #1;
    check("post_rst_ready", {AWREADY, WREADY, ARREADY}, 3'b111);

    // Basic writes and readback
    for (int i = 0; i < 4; i++) do_write(5'(4*i), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) do_read(5'(4*i));
    check("regs_o_basic", regs_o, 128'h00000004_00000003_00000002_00000001);

    // W ahead of AW by three cycles
    do_write(5'h04, 32'hDEADBEEF, 4'hF, 3, 0, 0);
    check("reg1_deadbeef", regs_o[63:32], 32'hDEADBEEF);

    // Byte strobes
    do_write(5'h00, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    do_write(5'h00, 32'h12345678, 4'h5, 0, 1, 0);
    do_read(5'h00);
    check("reg0_strobed", regs_o[31:0], 32'hFF34FF78);

    // B backpressure for 10 cycles
    do_write(5'h0C, 32'hA5A5_0F0F, 4'hF, 1, 0, 10);

    // Read and commit colliding on the same edge
    old_val = mdl[2];
    AWVALID = 1'b1; AWADDR = 5'h08; WVALID = 1'b1; WDATA = 32'h55; WSTRB = 4'hF;
    ARVALID = 1'b1; ARADDR = 5'h08;
    @(negedge clk);
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    check("collide_rvalid", RVALID, 1'b1);
    check("collide_rdata_old", RDATA, old_val);
    check("collide_bvalid", BVALID, 1'b1);
    check("collide_pulse", wr_pulse_o, 4'b0100);
    mdl_write(5'h08, 32'h55, 4'hF);
    BREADY = 1'b1; RREADY = 1'b1;
    @(negedge clk);
    BREADY = 1'b0; RREADY = 1'b0;
    do_read(5'h08);

    // Unmapped words
    do_read(5'h10);
    do_write(5'h14, 32'hCAFEF00D, 4'hF, 0, 2, 0);
    do_read(5'h1C);

    // Randomized traffic against the model
    for (int n = 0; n < 40; n++) begin
      do_write(5'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        ra = 5'($urandom_range(0, 31));
        do_read(ra);
      end
    end

    // Reset with a read response pending
    ARVALID = 1'b1; ARADDR = 5'h04; RREADY = 1'b0;
    @(negedge clk);
    ARVALID = 1'b0;
    check("pending_rvalid", RVALID, 1'b1);
    ARESET = 1'b1;
    @(negedge clk);
    check("rvalid_dropped_by_reset", RVALID, 1'b0);
    check("regs_cleared_by_reset", regs_o, 128'h0);
    ARESET = 1'b0;
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    #1;
    check("ready_after_reset", {AWREADY, WREADY, ARREADY}, 3'b111);

    // Reset with a W beat captured: the beat must be lost
    WVALID = 1'b1; WDATA = 32'h1111_2222; WSTRB = 4'hF;
    @(negedge clk);
    WVALID = 1'b0;
    check("w_captured", WREADY, 1'b0);
    ARESET = 1'b1;
    @(negedge clk);
    ARESET = 1'b0;
    #1;
    check("wready_after_reset", WREADY, 1'b1);
    check("bvalid_after_reset", BVALID, 1'b0);
    do_write(5'h00, 32'h0BAD_F00D, 4'hF, 0, 0, 0);
    do_read(5'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
